// File: rtl/cpu_mem_harness.sv
// CPU test harness: preloadable instruction/data memories, LOAD/RUN/HALTED sequencing, run/store counters.
// instr/readdata are combinational reads; memory writes, counters and the sticky error flag update on the rising edge.
module cpu_mem_harness #(
  parameter int                 DATA_W     = 16,
  parameter int                 PC_W       = 8,
  parameter int                 IMEM_DEPTH = 256,
  parameter int                 DMEM_DEPTH = 256,
  parameter int                 OPC_W      = 5,
  parameter logic [OPC_W-1:0]   HALT_OP    = 5'b11011,
  parameter logic [DATA_W-1:0]  NOP_WORD   = 16'h0800,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] instr,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [DATA_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  output logic              cpu_reset,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output logic              oob_err
);

  localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_store_cnt;
  logic              r_oob_err;
  logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

  logic              w_run;
  logic              w_load;
  logic              w_pc_ok;
  logic              w_alu_ok;
  logic              w_ld_iok;
  logic              w_ld_dok;
  logic              w_halt_fetch;
  logic              w_imem_we;
  logic              w_dmem_ld_we;
  logic              w_dmem_st_we;
  logic [DATA_W-1:0] w_instr;

  assign w_run    = (r_state == S_RUN);
  assign w_load   = (r_state == S_LOAD);
  assign w_pc_ok  = (32'(pc) < IMEM_DEPTH);
  assign w_alu_ok = (32'(aluout) < DMEM_DEPTH);
  assign w_ld_iok = (32'(ld_addr) < IMEM_DEPTH);
  assign w_ld_dok = (32'(ld_addr) < DMEM_DEPTH);

  always_comb begin
    w_instr = NOP_WORD;
    if (w_run && w_pc_ok)
      w_instr = r_imem[pc[IA_W-1:0]];
    else if (r_state == S_HALTED)
      w_instr = {HALT_OP, {(DATA_W-OPC_W){1'b0}}};
  end

  assign w_halt_fetch = w_run && (w_instr[DATA_W-1 -: OPC_W] == HALT_OP);

  // Reset dominates every write strobe in its cycle; memory itself is never cleared.
  assign w_imem_we    = !reset && w_load && ld_en && !ld_sel && w_ld_iok;
  assign w_dmem_ld_we = !reset && w_load && ld_en &&  ld_sel && w_ld_dok;
  assign w_dmem_st_we = !reset && w_run  && memwrite && w_alu_ok;

  always_ff @(posedge clk) begin
    if (w_imem_we)
      r_imem[ld_addr[IA_W-1:0]] <= ld_data;
    if (w_dmem_ld_we)
      r_dmem[ld_addr[DA_W-1:0]] <= ld_data;
    else if (w_dmem_st_we)
      r_dmem[aluout[DA_W-1:0]] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
      r_oob_err   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (ld_en && !(ld_sel ? w_ld_dok : w_ld_iok))
            r_oob_err <= 1'b1;
          if (start)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_cycle_cnt != {CNT_W{1'b1}})
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          if (memwrite && w_alu_ok && (r_store_cnt != {CNT_W{1'b1}}))
            r_store_cnt <= r_store_cnt + CNT_W'(1);
          if ((memwrite && !w_alu_ok) || !w_pc_ok)
            r_oob_err <= 1'b1;
          if (w_halt_fetch)
            r_state <= S_HALTED;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_LOAD;
      endcase
    end
  end

  assign instr     = w_instr;
  assign readdata  = w_alu_ok ? r_dmem[aluout[DA_W-1:0]] : '0;
  assign cpu_reset = !w_run;
  assign halted    = (r_state == S_HALTED);
  assign cycle_cnt = r_cycle_cnt;
  assign store_cnt = r_store_cnt;
  assign oob_err   = r_oob_err;

endmodule

// File: tb/tb_cpu_mem_harness.sv
// Randomized bench for cpu_mem_harness against a mode/array reference model, small memories and 4-bit counters.
module tb_cpu_mem_harness;

  localparam int IMD  = 32;
  localparam int DMD  = 16;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        reset, memwrite, ld_en, ld_sel, start;
  logic [7:0]  pc;
  logic [15:0] aluout, writedata, ld_addr, ld_data, instr, readdata;
  logic        cpu_reset, halted, oob_err;
  logic [3:0]  cycle_cnt, store_cnt;

  always #5 clk = ~clk;

  cpu_mem_harness #(
    .IMEM_DEPTH(IMD), .DMEM_DEPTH(DMD), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .readdata(readdata),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .cpu_reset(cpu_reset), .halted(halted),
    .cycle_cnt(cycle_cnt), .store_cnt(store_cnt), .oob_err(oob_err)
  );

  // Reference model: mode 0 = LOAD, 1 = RUN, 2 = HALTED.
  logic [15:0] m_imem [IMD];
  logic [15:0] m_dmem [DMD];
  int          mode;
  int          m_cyc, m_st;
  bit          m_oob;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rand_nohalt();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:11] == 5'b11011) w[15] = 1'b0;
    return w;
  endfunction

  // One clock: check outputs against the model at negedge, advance the model, return #1 after posedge.
  task automatic cyc();
    logic [15:0] e_instr, e_rd;
    @(negedge clk);
    if (mode == 1)      e_instr = (pc < IMD) ? m_imem[pc[4:0]] : 16'h0800;
    else if (mode == 2) e_instr = 16'hD800;
    else                e_instr = 16'h0800;
    e_rd = (aluout < DMD) ? m_dmem[aluout[3:0]] : 16'h0000;
    check("instr",     instr,     e_instr);
    check("readdata",  readdata,  e_rd);
    check("cpu_reset", cpu_reset, (mode != 1));
    check("halted",    halted,    (mode == 2));
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("store_cnt", store_cnt, m_st);
    check("oob_err",   oob_err,   m_oob);
    if (reset) begin
      mode = 0; m_cyc = 0; m_st = 0; m_oob = 0;
    end else if (mode == 0) begin
      if (ld_en) begin
        if (!ld_sel) begin
          if (ld_addr < IMD) m_imem[ld_addr[4:0]] = ld_data; else m_oob = 1;
        end else begin
          if (ld_addr < DMD) m_dmem[ld_addr[3:0]] = ld_data; else m_oob = 1;
        end
      end
      if (start) mode = 1;
    end else if (mode == 1) begin
      if (m_cyc < CMAX) m_cyc++;
      if (memwrite) begin
        if (aluout < DMD) begin
          m_dmem[aluout[3:0]] = writedata;
          if (m_st < CMAX) m_st++;
        end else m_oob = 1;
      end
      if (pc >= IMD) m_oob = 1;
      if (e_instr[15:11] == 5'b11011) mode = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic sel, input logic [15:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    cyc();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; start = 1'b0;
    pc = '0; aluout = '0; writedata = '0; ld_addr = '0; ld_data = '0;
    @(posedge clk);
    #1;
    mode = 0; m_cyc = 0; m_st = 0; m_oob = 0;
    do_reset();

    // Preload everything, then the two-instruction program.
    for (int i = 0; i < IMD; i++) load_word(1'b0, 16'(i), rand_nohalt());
    for (int i = 0; i < DMD; i++) load_word(1'b1, 16'(i), 16'($urandom));
    load_word(1'b0, 16'd0, 16'h8900);
    load_word(1'b0, 16'd1, 16'hD800);
    load_word(1'b1, 16'd0, 16'h00AB);
    start = 1'b1;
    cyc();
    start = 1'b0;
    pc = 8'd0; aluout = 16'd0;
    #1;
    check("r40_cpu_reset", cpu_reset, 0);
    check("r40_instr",     instr,     16'h8900);
    check("r40_readdata",  readdata,  16'h00AB);
    cyc();
    pc = 8'd1;
    cyc();
    check("r40_halted", halted,    1);
    check("r40_cycles", cycle_cnt, 2);

    // HALTED ignores stores and preloads.
    memwrite = 1'b1; aluout = 16'd3; writedata = 16'hFFFF;
    ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 16'd3; ld_data = 16'h0000;
    cyc();
    ld_sel = 1'b0; ld_addr = 16'd0;
    cyc();
    memwrite = 1'b0; ld_en = 1'b0;
    #1;
    check("r45_instr", instr, 16'hD800);
    for (int a = 0; a < DMD + 2; a++) begin
      aluout = 16'(a);
      cyc();
    end

    // Out-of-range preloads set the sticky flag; reset clears it.
    do_reset();
    load_word(1'b0, 16'd40, 16'h1111);
    load_word(1'b1, 16'd16, 16'h2222);
    check("ld_oob", oob_err, 1);
    load_word(1'b0, 16'd2, rand_nohalt());
    do_reset();

    start = 1'b1;
    cyc();
    start = 1'b0;
    pc = 8'd2; memwrite = 1'b1; aluout = 16'd2; writedata = 16'h1234;
    cyc();
    memwrite = 1'b0;
    #1;
    check("r41_new",   readdata,  16'h1234);
    check("r41_store", store_cnt, 1);
    cyc();
    memwrite = 1'b1; aluout = 16'h0010; writedata = 16'hBEEF;
    cyc();
    memwrite = 1'b0;
    #1;
    check("r42_oob",   oob_err,   1);
    check("r42_store", store_cnt, 1);
    cyc();

    for (int i = 0; i < 16; i++) begin
      memwrite = 1'b1; aluout = 16'($urandom_range(0, DMD - 1)); writedata = 16'($urandom);
      cyc();
    end
    for (int i = 0; i < 40; i++) begin
      pc        = 8'($urandom_range(0, IMD + 7));
      memwrite  = 1'($urandom_range(0, 1));
      aluout    = 16'($urandom_range(0, DMD + 3));
      writedata = 16'($urandom);
      start     = 1'($urandom_range(0, 1));
      ld_en     = 1'($urandom_range(0, 1));
      ld_sel    = 1'($urandom_range(0, 1));
      ld_addr   = 16'($urandom_range(0, DMD - 1));
      ld_data   = 16'($urandom);
      cyc();
    end
    memwrite = 1'b0; start = 1'b0; ld_en = 1'b0;
    #1;
    check("r43_cyc_sat", cycle_cnt, 4'hF);
    check("st_sat",      store_cnt, 4'hF);

    // Reset mid-RUN with a simultaneous start, then rerun over the whole program.
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 8'($urandom_range(0, IMD - 1)); memwrite = 1'($urandom_range(0, 1));
      aluout = 16'($urandom_range(0, DMD - 1)); writedata = 16'($urandom);
      cyc();
    end
    reset = 1'b1; start = 1'b1; memwrite = 1'b1; aluout = 16'd5;
    cyc();
    reset = 1'b0; start = 1'b0; memwrite = 1'b0;
    #1;
    check("r44_cpu_reset", cpu_reset, 1);
    check("r44_cycles",    cycle_cnt, 0);
    check("r44_stores",    store_cnt, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < IMD; i++) begin
      pc = 8'(i); aluout = 16'(i % DMD);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_harness.md
CPU_MEM_HARNESS -- requirements
Module: cpu_mem_harness

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction/data word width.
REQ-002 SHALL have parameter PC_W, default 8, CPU program-counter width.
REQ-003 SHALL have parameter IMEM_DEPTH, default 256, instruction words (<= 2^PC_W).
REQ-004 SHALL have parameter DMEM_DEPTH, default 256, data words (<= 2^DATA_W).
REQ-005 SHALL have parameter OPC_W, default 5, opcode field width (instr[DATA_W-1 -: OPC_W]).
REQ-006 SHALL have parameter HALT_OP, default 5'b11011, halt opcode.
REQ-007 SHALL have parameter NOP_WORD, default 16'h0800, instruction driven when not running.
REQ-008 SHALL have parameter CNT_W, default 16, counter width.
REQ-009 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-010 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-011 SHALL have port pc  input  PC_W  CPU fetch address.
REQ-012 SHALL have port instr  output  DATA_W  fetched instruction.
REQ-013 SHALL have port memwrite  input  1  CPU store strobe.
REQ-014 SHALL have port aluout  input  DATA_W  CPU data address.
REQ-015 SHALL have port writedata  input  DATA_W  CPU store data.
REQ-016 SHALL have port readdata  output  DATA_W  CPU load data.
REQ-017 SHALL have port ld_en  input  1  program/data preload strobe.
REQ-018 SHALL have port ld_sel  input  1  preload target: 0 imem, 1 dmem.
REQ-019 SHALL have port ld_addr  input  DATA_W  preload word address.
REQ-020 SHALL have port ld_data  input  DATA_W  preload word.
REQ-021 SHALL have port start  input  1  single-cycle pulse, LOAD -> RUN.
REQ-022 SHALL have port cpu_reset  output  1  reset to CPU, high outside RUN.
REQ-023 SHALL have port halted  output  1  high in HALTED.
REQ-024 SHALL have port cycle_cnt  output  CNT_W  RUN cycles elapsed.
REQ-025 SHALL have port store_cnt  output  CNT_W  accepted CPU stores.
REQ-026 SHALL have port oob_err  output  1  sticky out-of-range access flag.

Function
REQ-027 SHALL implement FSM LOAD, RUN, HALTED, registered; cpu_reset = (state!=RUN), halted = (state==HALTED), both decoded from the state register.
REQ-028 LOAD: ld_en writes ld_data to imem/dmem[ld_addr] at the edge; ld_addr >= target depth -> write dropped, oob_err set; ld_en ignored in RUN/HALTED.
REQ-029 LOAD -> RUN on the edge where start=1; simultaneous ld_en is still performed; start ignored in RUN/HALTED.
REQ-030 instr SHALL be combinational: RUN and pc < IMEM_DEPTH -> imem[pc]; RUN and pc out of range -> NOP_WORD, oob_err set next edge; LOAD -> NOP_WORD; HALTED -> {HALT_OP, zeros}.
REQ-031 readdata SHALL be combinational dmem[aluout] when aluout < DMEM_DEPTH, else 0; no flag on read.
REQ-032 RUN: memwrite=1 with aluout < DMEM_DEPTH writes writedata at the edge and increments store_cnt; aluout out of range -> write dropped, store_cnt unchanged, oob_err set.
REQ-033 memwrite SHALL be ignored outside RUN.
REQ-034 cycle_cnt increments every RUN cycle including the halt-fetch cycle; frozen in LOAD/HALTED.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-036 RUN -> HALTED on the edge where instr opcode == HALT_OP; a store in that same cycle is still performed; HALTED exits only via reset.
REQ-037 Store and load of the same address in one cycle: readdata shows old data; new data visible next cycle.

Reset
REQ-038 reset=1 at an edge SHALL force LOAD, cycle_cnt=0, store_cnt=0, oob_err=0, hence cpu_reset=1, halted=0; dominates start/ld_en/memwrite in that cycle.
REQ-039 Memory contents SHALL NOT be cleared by reset; reset mid-RUN keeps imem/dmem, allowing rerun after another start.

Verification
REQ-040 Preload imem[0]=16'h8900 (LOAD), imem[1]=16'hD800 (HALT), dmem[0]=16'h00AB, start -> cpu_reset falls next edge; pc=0 gives instr 8900, readdata 00AB at aluout 0; pc=1 -> halted=1 next edge, cycle_cnt=2.
REQ-041 RUN, memwrite=1, aluout=2, writedata=16'h1234 -> same-cycle readdata old value, next cycle 1234, store_cnt=1.
REQ-042 DMEM_DEPTH=16, store to aluout=16'h0010 -> dmem unchanged, store_cnt unchanged, oob_err=1 until reset.
REQ-043 CNT_W=4, 20 RUN cycles -> cycle_cnt holds 4'hF.
REQ-044 Reset asserted mid-RUN after 5 cycles with start=1 same cycle -> state LOAD, counters 0, imem intact; new start reruns identical program.
REQ-045 In HALTED, memwrite=1 and ld_en=1 -> no memory change, instr = 16'hD800.
